// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: aligns stores, formats loads, stalls the pipeline across bus waits.
// Latency: 3 cycles per access with zero-wait memory (IDLE, WAIT, DONE); 1 cycle for non-memory ops.
// Backpressure: StallM stays high until the bus returns dmem_ready or the timeout fault fires.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [63:0] ALU_ResultM,
    input  logic [63:0] WriteDataM,
    input  logic        RegWriteM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [7:0]  dmem_be,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        StallM,
    output logic [63:0] ReadDataM,
    output logic        RegWriteO,
    output logic        fault_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [7:0]  r_be;
    logic [63:0] r_wdata;
    logic [2:0]  r_f3;
    logic [2:0]  r_lane;
    logic [63:0] r_rdata;
    logic        r_fault;
    logic [15:0] r_cnt;

    logic        w_mem_op;
    logic [2:0]  w_lane;
    logic        w_misalign;
    logic        w_illegal;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [63:0] w_rd_shift;
    logic [63:0] w_fmt;
    logic [15:0] w_cnt_nxt;
    logic        w_issue;
    logic        w_flt_idle;
    logic        w_rsp;
    logic        w_tmo;

    assign w_mem_op  = MemReadM | MemWriteM;
    assign w_lane    = ALU_ResultM[2:0];
    assign w_cnt_nxt = r_cnt + 16'd1;

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 8'h01 << w_lane;
        case (funct3M[1:0])
            2'b01: begin w_misalign = w_lane[0];    w_be = 8'h03 << w_lane; end
            2'b10: begin w_misalign = |w_lane[1:0]; w_be = 8'h0F << w_lane; end
            2'b11: begin w_misalign = |w_lane;      w_be = 8'hFF;           end
            default: ;
        endcase
    end

    // Stores have no unsigned forms, and 111 is not a defined access size.
    assign w_illegal = (MemReadM & MemWriteM) | (MemWriteM & funct3M[2]) |
                       (funct3M == 3'b111) | w_misalign;
    assign w_wdata   = WriteDataM << {w_lane, 3'b000};

    assign w_rd_shift = dmem_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_fmt = dmem_rdata;
        case (r_f3)
            3'b000:  w_fmt = {{56{w_rd_shift[7]}},  w_rd_shift[7:0]};
            3'b001:  w_fmt = {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b010:  w_fmt = {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
            3'b100:  w_fmt = {56'd0, w_rd_shift[7:0]};
            3'b101:  w_fmt = {48'd0, w_rd_shift[15:0]};
            3'b110:  w_fmt = {32'd0, w_rd_shift[31:0]};
            default: w_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        StallM      = 1'b0;
        ReadDataM   = 64'd0;
        fault_o     = 1'b0;
        RegWriteO   = RegWriteM;
        w_issue     = 1'b0;
        w_flt_idle  = 1'b0;
        w_rsp       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    StallM    = 1'b1;
                    RegWriteO = 1'b0;
                    if (w_illegal) begin
                        w_flt_idle  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                StallM    = 1'b1;
                RegWriteO = 1'b0;
                if (dmem_ready) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_cnt_nxt == LP_TIMEOUT) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ReadDataM   = r_rdata;
                fault_o     = r_fault;
                RegWriteO   = RegWriteM & ~r_fault;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 64'd0;
            r_be    <= 8'd0;
            r_wdata <= 64'd0;
            r_f3    <= 3'd0;
            r_lane  <= 3'd0;
            r_rdata <= 64'd0;
            r_fault <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= MemWriteM;
                r_addr  <= {ALU_ResultM[63:3], 3'b000};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_f3    <= funct3M;
                r_lane  <= w_lane;
                r_rdata <= 64'd0;
            end
            if (w_flt_idle) begin
                r_fault <= 1'b1;
                r_rdata <= 64'd0;
            end
            if (r_state == S_WAIT) begin
                if (w_rsp) begin
                    r_req   <= 1'b0;
                    r_rdata <= r_we ? 64'd0 : w_fmt;
                    r_cnt   <= 16'd0;
                end else if (w_tmo) begin
                    r_req   <= 1'b0;
                    r_fault <= 1'b1;
                    r_rdata <= 64'd0;
                    r_cnt   <= 16'd0;
                end else begin
                    r_cnt   <= w_cnt_nxt;
                end
            end
            if (r_state == S_DONE) r_fault <= 1'b0;
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults, timeout and reset mid-access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, RegWriteM;
    logic [2:0]  funct3M;
    logic [63:0] ALU_ResultM, WriteDataM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_be;
    logic        StallM, RegWriteO, fault_o;
    logic [63:0] ReadDataM;

    int n_checks = 0;
    int n_err    = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .RegWriteM(RegWriteM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .ReadDataM(ReadDataM), .RegWriteO(RegWriteO), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd);
        MemReadM    = rd;
        MemWriteM   = wr;
        funct3M     = f3;
        ALU_ResultM = addr;
        WriteDataM  = wd;
    endtask

    // Advance to the middle of the next cycle; inputs set afterwards settle before the next edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        RegWriteM = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 64'd0;
        set_op(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
        #1;
        check("rst_req",   {63'd0, dmem_req}, 64'd0);
        check("rst_we",    {63'd0, dmem_we},  64'd0);
        check("rst_addr",  dmem_addr,         64'd0);
        check("rst_be",    {56'd0, dmem_be},  64'd0);
        check("rst_wdata", dmem_wdata,        64'd0);
        check("rst_stall", {63'd0, StallM},   64'd0);
        check("rst_fault", {63'd0, fault_o},  64'd0);

        next_cycle(); reset = 1'b0;
        #1;
        check("idle_rdata", ReadDataM,          64'd0);
        check("idle_rw",    {63'd0, RegWriteO}, 64'd1);

        // LB 0x1003, ready also high in IDLE (ignored there)
        next_cycle(); set_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0);
        dmem_ready = 1'b1; dmem_rdata = 64'h0000_0000_8000_0000;
        #1;
        check("lb_stall0", {63'd0, StallM},   64'd1);
        check("lb_req0",   {63'd0, dmem_req}, 64'd0);
        next_cycle(); #1;
        check("lb_stall1", {63'd0, StallM},   64'd1);
        check("lb_req1",   {63'd0, dmem_req}, 64'd1);
        check("lb_addr",   dmem_addr,         64'h1000);
        check("lb_be",     {56'd0, dmem_be},  64'h08);
        check("lb_we",     {63'd0, dmem_we},  64'd0);
        next_cycle(); dmem_ready = 1'b0; #1;
        check("lb_stall2", {63'd0, StallM},    64'd0);
        check("lb_req2",   {63'd0, dmem_req},  64'd0);
        check("lb_data",   ReadDataM,          64'hFFFF_FFFF_FFFF_FF80);
        check("lb_fault",  {63'd0, fault_o},   64'd0);
        check("lb_rw",     {63'd0, RegWriteO}, 64'd1);

        // SH 0x2006
        next_cycle(); set_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD); #1;
        check("sh_stall0", {63'd0, StallM}, 64'd1);
        next_cycle(); dmem_ready = 1'b1; dmem_rdata = 64'h1234_5678_9ABC_DEF0; #1;
        check("sh_be",    {56'd0, dmem_be},  64'hC0);
        check("sh_wdata", dmem_wdata,        64'hABCD_0000_0000_0000);
        check("sh_we",    {63'd0, dmem_we},  64'd1);
        check("sh_addr",  dmem_addr,         64'h2000);
        next_cycle(); dmem_ready = 1'b0; #1;
        check("sh_data",  ReadDataM,         64'd0);
        check("sh_stall2", {63'd0, StallM},  64'd0);

        // LW misaligned 0x3002
        next_cycle(); set_op(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0); #1;
        check("lw_stall0", {63'd0, StallM},   64'd1);
        next_cycle(); #1;
        check("lw_req",    {63'd0, dmem_req},  64'd0);
        check("lw_fault",  {63'd0, fault_o},   64'd1);
        check("lw_rw",     {63'd0, RegWriteO}, 64'd0);
        check("lw_stall1", {63'd0, StallM},    64'd0);
        next_cycle(); set_op(1'b0, 1'b0, 3'b000, 64'd0, 64'd0); #1;
        check("lw_idle_fault", {63'd0, fault_o}, 64'd0);

        // SBU-encoded store (illegal size)
        next_cycle(); set_op(1'b0, 1'b1, 3'b100, 64'h40, 64'h55); #1;
        next_cycle(); #1;
        check("sbu_fault", {63'd0, fault_o},  64'd1);
        check("sbu_req",   {63'd0, dmem_req}, 64'd0);

        // LD aligned with read and write both set (illegal)
        next_cycle(); set_op(1'b1, 1'b1, 3'b011, 64'h48, 64'h0); #1;
        next_cycle(); #1;
        check("rdwr_fault", {63'd0, fault_o}, 64'd1);

        // LD 0x4000, bus never answers, timeout after 4 WAIT cycles
        next_cycle(); set_op(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0); #1;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            check($sformatf("ld_req_w%0d", i),   {63'd0, dmem_req}, 64'd1);
            check($sformatf("ld_stall_w%0d", i), {63'd0, StallM},   64'd1);
        end
        next_cycle(); #1;
        check("ld_req_done", {63'd0, dmem_req},  64'd0);
        check("ld_fault",    {63'd0, fault_o},   64'd1);
        check("ld_data",     ReadDataM,          64'd0);
        check("ld_stall",    {63'd0, StallM},    64'd0);
        check("ld_rw",       {63'd0, RegWriteO}, 64'd0);

        // LWU 0x10, ready in the third WAIT cycle
        next_cycle(); set_op(1'b1, 1'b0, 3'b110, 64'h10, 64'd0);
        dmem_rdata = 64'hFFFF_FFFF_8765_4321; #1;
        check("lwu_stall0", {63'd0, StallM}, 64'd1);
        next_cycle(); #1; check("lwu_stall1", {63'd0, StallM}, 64'd1);
        next_cycle(); #1; check("lwu_stall2", {63'd0, StallM}, 64'd1);
        check("lwu_be", {56'd0, dmem_be}, 64'h0F);
        next_cycle(); dmem_ready = 1'b1; #1;
        check("lwu_stall3", {63'd0, StallM}, 64'd1);
        next_cycle(); dmem_ready = 1'b0; #1;
        check("lwu_stall4", {63'd0, StallM}, 64'd0);
        check("lwu_data",   ReadDataM,       64'h0000_0000_8765_4321);
        check("lwu_fault",  {63'd0, fault_o}, 64'd0);

        // LH 0x5006, reset pulse mid-WAIT, late ready ignored
        next_cycle(); set_op(1'b1, 1'b0, 3'b001, 64'h5006, 64'd0); #1;
        next_cycle(); #1;
        check("rw_req_wait", {63'd0, dmem_req}, 64'd1);
        reset = 1'b1; #1;
        check("rw_req_rst",  {63'd0, dmem_req}, 64'd0);
        check("rw_addr_rst", dmem_addr,         64'd0);
        next_cycle(); reset = 1'b0; set_op(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
        dmem_ready = 1'b1; #1;
        check("rw_stall", {63'd0, StallM},  64'd0);
        next_cycle(); #1;
        check("rw_req_late", {63'd0, dmem_req}, 64'd0);
        check("rw_stall2",   {63'd0, StallM},   64'd0);
        check("rw_data",     ReadDataM,         64'd0);
        check("rw_fault",    {63'd0, fault_o},  64'd0);
        dmem_ready = 1'b0;

        next_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before bus-timeout fault (1..65535).
REQ-002 SHALL have ports, clock and reset first, named exactly as listed in REQ-003 to REQ-021; reset is asynchronous, active-high; clock is clk.
REQ-003 clk  in  1  clock, rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 MemReadM  in  1  load in MEM stage.
REQ-006 MemWriteM  in  1  store in MEM stage.
REQ-007 funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
REQ-008 ALU_ResultM  in  64  effective address.
REQ-009 WriteDataM  in  64  store data, LSB-aligned.
REQ-010 RegWriteM  in  1  register-write control from EX/MEM.
REQ-011 dmem_req  out  1  bus request, registered.
REQ-012 dmem_we  out  1  1 = write.
REQ-013 dmem_addr  out  64  doubleword-aligned address (bits [2:0] = 0).
REQ-014 dmem_be  out  8  byte enables.
REQ-015 dmem_wdata  out  64  lane-shifted store data.
REQ-016 dmem_ready  in  1  bus completion, sampled only in WAIT.
REQ-017 dmem_rdata  in  64  read doubleword, valid with dmem_ready.
REQ-018 StallM  out  1  freezes PC/IF/ID/EX/MEM regs and holds MEM/WB input.
REQ-019 ReadDataM  out  64  formatted load data to MEM/WB.
REQ-020 RegWriteO  out  1  RegWriteM gated by fault.
REQ-021 fault_o  out  1  misaligned, illegal-size, or timeout fault.

Function
REQ-022 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-023 IDLE, no mem op: StallM=0, ReadDataM=0, fault_o=0, RegWriteO=RegWriteM, stay IDLE.
REQ-024 IDLE, mem op (MemReadM|MemWriteM): StallM=1; if aligned and legal, register dmem_addr/we/be/wdata, go WAIT; else set fault_q, go DONE.
REQ-025 Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0; store funct3 1xx is illegal; MemReadM&MemWriteM is illegal.
REQ-026 WAIT: dmem_req=1, StallM=1; on dmem_ready, latch formatted data into rdata_q, clear counter, go DONE.
REQ-027 WAIT: 16-bit counter increments per cycle without ready; at count==TIMEOUT_CYCLES, set fault_q, rdata_q=0, drop dmem_req, go DONE.
REQ-028 DONE: StallM=0, dmem_req=0, ReadDataM=rdata_q (0 for stores/faults), fault_o=fault_q, RegWriteO=RegWriteM&~fault_q; next edge unconditionally go IDLE, clear fault_q.
REQ-029 Load format: select byte lane addr[2:0], sign-extend B/H/W, zero-extend BU/HU/WU, D passes through.
REQ-030 Store enables: B 1 bit at addr[2:0], H 2 bits, W 4 bits, D 8'hFF; wdata shifted left by 8*addr[2:0].
REQ-031 Zero-wait memory SHALL give 3 cycles in MEM per access (IDLE, WAIT, DONE); non-memory ops 1 cycle.
REQ-032 dmem_ready outside WAIT SHALL be ignored.
REQ-033 dmem outputs SHALL remain stable throughout WAIT.

Reset
REQ-034 reset SHALL asynchronously force IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, rdata_q=0, fault_q=0, counter=0.
REQ-035 reset asserted in WAIT SHALL abandon the access with no further request; a late dmem_ready SHALL be ignored.
REQ-036 After deassertion, the first rising edge SHALL evaluate IDLE inputs normally.

Verification
REQ-037 LB, addr 0x1003, rdata 0x0000_0000_8000_0000, ready in first WAIT -> dmem_addr 0x1000, StallM 1,1,0, ReadDataM 0xFFFF_FFFF_FFFF_FF80 in DONE.
REQ-038 SH, addr 0x2006, WriteDataM 0xABCD -> dmem_be 8'hC0, dmem_wdata 0xABCD_0000_0000_0000, dmem_we 1, ReadDataM 0.
REQ-039 LW, addr 0x3002 -> no dmem_req, fault_o 1 and RegWriteO 0 in DONE, StallM 1 then 0.
REQ-040 LD, TIMEOUT_CYCLES=4, ready never -> dmem_req high 4 cycles then 0, fault_o 1, ReadDataM 0.
REQ-041 LWU, addr 0x10, ready after 3 WAIT cycles, rdata 0xFFFF_FFFF_8765_4321 -> StallM high 4 cycles, ReadDataM 0x0000_0000_8765_4321.
REQ-042 reset pulse mid-WAIT, then dmem_ready=1 -> dmem_req 0 immediately, state IDLE, ReadDataM 0, no fault.
